// File: rtl/pc_seq_unit.sv
// Program sequencer: PC register with flag-conditioned absolute/relative branches,
// halt/stall control and an optional call/return stack (enabled by PC_SEQ_STACK_EN).
module pc_seq_unit #(
  parameter int D = 12,
  parameter int S = 4,
  parameter logic [D-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   halt,
  input  logic                   absBranch,
  input  logic                   relBranch,
  input  logic                   branchInvert,
  input  logic                   branchFlag,
  input  logic                   flagNgtv,
  input  logic                   flagZero,
  input  logic                   call,
  input  logic                   ret,
  input  logic [D-1:0]           target,
  output logic [D-1:0]           progCtr,
  output logic                   done,
  output logic [$clog2(S+1)-1:0] depth,
  output logic                   stackErr
);

  localparam int DW = $clog2(S + 1);

  logic [D-1:0]  pcReg, pcNext, pcInc;
  logic          doneReg, doneNext;
  logic          cond;

`ifdef PC_SEQ_STACK_EN
  localparam int AW = (S > 1) ? $clog2(S) : 1;
  localparam logic [DW-1:0] FULL = DW'(S);

  logic [DW-1:0] depthReg, depthNext;
  logic          errReg, errNext;
  logic          push;
  logic [AW-1:0] pushIdx, topIdx;
  logic [D-1:0]  stackMem [S];

  assign pushIdx = depthReg[AW-1:0];
  assign topIdx  = AW'(depthReg - 1'b1);
`endif

  assign cond  = (branchFlag ? flagNgtv : flagZero) ^ branchInvert;
  assign pcInc = pcReg + 1'b1;

  always_comb begin
    pcNext    = pcReg;
    doneNext  = doneReg;
`ifdef PC_SEQ_STACK_EN
    depthNext = depthReg;
    errNext   = errReg;
    push      = 1'b0;
`endif
    // A halted sequencer and a stalled one both hold every register.
    if (!doneReg && !stall) begin
      if (halt) begin
        doneNext = 1'b1;
      end else if (ret) begin
`ifdef PC_SEQ_STACK_EN
        if (depthReg != '0) begin
          pcNext    = stackMem[topIdx];
          depthNext = depthReg - 1'b1;
        end else begin
          errNext  = 1'b1;
          doneNext = 1'b1;
        end
`else
        pcNext = pcInc;
`endif
      end else if (call) begin
`ifdef PC_SEQ_STACK_EN
        if (depthReg != FULL) begin
          push      = 1'b1;
          depthNext = depthReg + 1'b1;
          pcNext    = target;
        end else begin
          errNext  = 1'b1;
          doneNext = 1'b1;
        end
`else
        pcNext = target;
`endif
      end else if (absBranch) begin
        pcNext = cond ? target : pcInc;
      end else if (relBranch) begin
        // Offset is two's complement; D-bit addition wraps modulo 2^D.
        pcNext = cond ? (pcReg + target) : pcInc;
      end else begin
        pcNext = pcInc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg   <= RESET_PC;
      doneReg <= 1'b0;
`ifdef PC_SEQ_STACK_EN
      depthReg <= '0;
      errReg   <= 1'b0;
`endif
    end else begin
      pcReg   <= pcNext;
      doneReg <= doneNext;
`ifdef PC_SEQ_STACK_EN
      depthReg <= depthNext;
      errReg   <= errNext;
`endif
    end
  end

`ifdef PC_SEQ_STACK_EN
  // Stack entries carry no reset; occupancy alone defines validity.
  for (genvar gi = 0; gi < S; gi++) begin : gStack
    always_ff @(posedge clk) begin
      if (push && (pushIdx == AW'(gi))) begin
        stackMem[gi] <= pcInc;
      end
    end
  end

  assign depth    = depthReg;
  assign stackErr = errReg;
`else
  assign depth    = '0;
  assign stackErr = 1'b0;
`endif

  assign progCtr = pcReg;
  assign done    = doneReg;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed self-checking bench for pc_seq_unit (D=12, S=4, RESET_PC=0);
// stack-specific steps follow the PC_SEQ_STACK_EN build option.
module tb_pc_seq_unit;

  logic        clk = 1'b0;
  logic        reset, stall, halt, absBranch, relBranch;
  logic        branchInvert, branchFlag, flagNgtv, flagZero, call, ret;
  logic [11:0] target;
  logic [11:0] progCtr;
  logic        done;
  logic [2:0]  depth;
  logic        stackErr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_seq_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt),
    .absBranch(absBranch), .relBranch(relBranch),
    .branchInvert(branchInvert), .branchFlag(branchFlag),
    .flagNgtv(flagNgtv), .flagZero(flagZero),
    .call(call), .ret(ret), .target(target),
    .progCtr(progCtr), .done(done), .depth(depth), .stackErr(stackErr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; halt = 0; absBranch = 0; relBranch = 0; call = 0; ret = 0;
  endtask

  // Unconditional jump: flagZero=1 selected, not inverted.
  task automatic jump(input logic [11:0] addr);
    idle();
    branchFlag = 0; flagZero = 1; branchInvert = 0;
    absBranch = 1; target = addr;
    tick();
    absBranch = 0;
  endtask

  initial begin
    idle();
    reset = 1; branchInvert = 0; branchFlag = 0; flagNgtv = 0; flagZero = 0;
    target = '0;
    tick();
    check("reset_pc", 32'(progCtr), 0);
    check("reset_done", 32'(done), 0);
    check("reset_depth", 32'(depth), 0);
    check("reset_err", 32'(stackErr), 0);
    $display("reset: pc=%h done=%b", progCtr, done);

    reset = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("idle_inc", 32'(progCtr), 32'(i));
      $display("idle %0d: pc=%h", i, progCtr);
    end
    check("idle_done", 32'(done), 0);

    // Relative branch taken backwards by 3, then not taken when inverted.
    jump(12'h010);
    relBranch = 1; target = 12'hFFD; flagZero = 1; branchFlag = 0; branchInvert = 0;
    tick();
    check("rel_taken", 32'(progCtr), 32'h00D);
    $display("rel taken: pc=%h", progCtr);
    jump(12'h010);
    relBranch = 1; target = 12'hFFD; flagZero = 1; branchInvert = 1;
    tick();
    check("rel_not_taken", 32'(progCtr), 32'h011);
    $display("rel not taken: pc=%h", progCtr);
    relBranch = 0; branchInvert = 0;

    // Negative flag select, taken and not taken; abs beats rel.
    branchFlag = 1; flagNgtv = 1; flagZero = 0; absBranch = 1; target = 12'h200;
    tick();
    check("abs_ngtv_taken", 32'(progCtr), 32'h200);
    flagNgtv = 0;
    tick();
    check("abs_ngtv_not", 32'(progCtr), 32'h201);
    flagNgtv = 1; relBranch = 1; target = 12'h050;
    tick();
    check("abs_over_rel", 32'(progCtr), 32'h050);
    $display("abs/rel priority: pc=%h", progCtr);
    idle();

    // Call then return.
    jump(12'h020);
    call = 1; target = 12'h100;
    tick();
    call = 0;
    check("call_pc", 32'(progCtr), 32'h100);
`ifdef PC_SEQ_STACK_EN
    check("call_depth", 32'(depth), 1);
`else
    check("call_depth", 32'(depth), 0);
`endif
    ret = 1;
    tick();
    ret = 0;
`ifdef PC_SEQ_STACK_EN
    check("ret_pc", 32'(progCtr), 32'h021);
`else
    check("ret_pc", 32'(progCtr), 32'h101);
`endif
    check("ret_depth", 32'(depth), 0);
    $display("call/ret: pc=%h depth=%0d", progCtr, depth);

    // Wrap and stall with a held request.
    jump(12'hFFF);
    tick();
    check("wrap", 32'(progCtr), 0);
    stall = 1; absBranch = 1; target = 12'h300;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", 32'(progCtr), 0);
    end
    stall = 0;
    tick();
    check("stall_resume", 32'(progCtr), 32'h300);
    absBranch = 0;
    tick();
    check("stall_after", 32'(progCtr), 32'h301);
    $display("wrap/stall: pc=%h", progCtr);

    // Halt held under stall, then taking effect; done is sticky.
    jump(12'h030);
    halt = 1; stall = 1;
    tick();
    check("halt_stalled_done", 32'(done), 0);
    check("halt_stalled_pc", 32'(progCtr), 32'h030);
    stall = 0;
    tick();
    check("halt_done", 32'(done), 1);
    halt = 0; absBranch = 1; target = 12'h555;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_pc_hold", 32'(progCtr), 32'h030);
    end
    check("halt_sticky", 32'(done), 1);
    idle();
    reset = 1;
    tick();
    reset = 0;
    check("halt_reset_pc", 32'(progCtr), 0);
    check("halt_reset_done", 32'(done), 0);
    $display("halt/reset: pc=%h done=%b", progCtr, done);

`ifdef PC_SEQ_STACK_EN
    // Overflow on the fifth nested call.
    for (int i = 1; i <= 4; i++) begin
      call = 1; target = 12'(12'h100 * i);
      tick();
      check("nest_pc", 32'(progCtr), 32'(12'h100 * i));
      check("nest_depth", 32'(depth), 32'(i));
    end
    target = 12'h700;
    tick();
    call = 0;
    check("ovf_pc", 32'(progCtr), 32'h400);
    check("ovf_err", 32'(stackErr), 1);
    check("ovf_done", 32'(done), 1);
    check("ovf_depth", 32'(depth), 4);
    $display("overflow: pc=%h err=%b depth=%0d", progCtr, stackErr, depth);
    reset = 1;
    tick();
    reset = 0;
    check("err_reset", 32'(stackErr), 0);
    ret = 1;
    tick();
    ret = 0;
    check("udf_err", 32'(stackErr), 1);
    check("udf_done", 32'(done), 1);
    check("udf_pc", 32'(progCtr), 0);
    $display("underflow: pc=%h err=%b", progCtr, stackErr);
`else
    // Without a stack, ret increments and outranks call.
    ret = 1; call = 1; target = 12'h700;
    tick();
    idle();
    check("noStack_ret", 32'(progCtr), 1);
    check("noStack_err", 32'(stackErr), 0);
    check("noStack_depth", 32'(depth), 0);
    $display("no stack: pc=%h", progCtr);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
